// File: rtl/chrom_fitness_evaluator.sv
// Fabric-side chromosome evaluator: drives up to NUM_SEQ stimulus words into the evolved circuit,
// samples its response after a settle delay and accumulates per-output-bit mismatch counts.
// Optional build macro EVAL_CYCLE_COUNT_EN adds the eval_cycles busy-cycle counter output.
module chrom_fitness_evaluator #(
   parameter int NUM_SEQ       = 16,
   parameter int NUM_OUT       = 8,
   parameter int NUM_IN        = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_processing_chrom,
   input  logic                   done_processing_feedback,
   input  logic [31:0]            sequences_to_process,
   input  logic [NUM_SEQ*32-1:0]  input_sequence,
   input  logic [NUM_SEQ*32-1:0]  expected_output,
   input  logic [NUM_SEQ*32-1:0]  valid_output,
   output logic [NUM_IN-1:0]      circuit_in,
   input  logic [NUM_OUT-1:0]     circuit_out,
   output logic                   ready_to_process,
   output logic                   done_processing_chrom,
`ifdef EVAL_CYCLE_COUNT_EN
   output logic [31:0]            eval_cycles,
`endif
   output logic [NUM_OUT*32-1:0]  error_sum
);

   localparam int IDX_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
   localparam int CNT_W = $clog2(NUM_SEQ + 1);
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_APPLY   = 3'd1,
      S_SETTLE  = 3'd2,
      S_COMPARE = 3'd3,
      S_DONE    = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     seq_count_q, seq_count_d;
   logic [SET_W-1:0]     settle_q, settle_d;
   logic [NUM_IN-1:0]    cin_q, cin_d;
   logic [NUM_OUT-1:0]   sample_q, sample_d;
   logic [31:0]          err_q [NUM_OUT];
   logic [31:0]          err_d [NUM_OUT];
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic                 accept_s;
   logic                 last_s;
   logic [IDX_W+4:0]     base_s;
   logic [NUM_OUT-1:0]   mism_s;
   logic [CNT_W-1:0]     seq_clamp_s;
   logic                 unused_inputs_s;

   // Only the low bits of each packed word feed the datapath.
   assign unused_inputs_s = ^{input_sequence, expected_output, valid_output, sequences_to_process};

   assign base_s   = {idx_q, 5'd0};
   assign mism_s   = (sample_q ^ expected_output[base_s +: NUM_OUT]) & valid_output[base_s +: NUM_OUT];
   assign last_s   = (CNT_W'(idx_q) == (seq_count_q - CNT_W'(1)));
   assign accept_s = (state_q == S_IDLE) && start_processing_chrom && !done_processing_feedback;

   // Clamp the requested vector count to the table depth.
   always_comb begin
      if (sequences_to_process > 32'(NUM_SEQ)) begin
         seq_clamp_s = CNT_W'(NUM_SEQ);
      end else begin
         seq_clamp_s = sequences_to_process[CNT_W-1:0];
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      seq_count_d = seq_count_q;
      settle_d    = settle_q;
      cin_d       = cin_q;
      sample_d    = sample_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               for (int k = 0; k < NUM_OUT; k++) begin
                  err_d[k] = 32'd0;
               end
               idx_d       = '0;
               seq_count_d = seq_clamp_s;
               if (seq_clamp_s == CNT_W'(0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_APPLY;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_APPLY: begin
            cin_d    = input_sequence[base_s +: NUM_IN];
            settle_d = SET_W'(SETTLE_CYCLES - 1);
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SET_W'(0)) begin
               sample_d = circuit_out;
               state_d  = S_COMPARE;
            end else begin
               settle_d = settle_q - SET_W'(1);
            end
         end
         S_COMPARE: begin
            for (int k = 0; k < NUM_OUT; k++) begin
               err_d[k] = err_q[k] + 32'(mism_s[k]);
            end
            if (last_s) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_APPLY;
            end
         end
         S_DONE: begin
            if (done_processing_feedback) begin
               state_d = S_RELEASE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_RELEASE: begin
            // Hold here until the host lets go of both lines so a held start cannot retrigger.
            if (!start_processing_chrom && !done_processing_feedback) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RELEASE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         seq_count_q <= '0;
         settle_q    <= '0;
         cin_q       <= '0;
         sample_q    <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) begin
            err_q[k] <= 32'd0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         seq_count_q <= seq_count_d;
         settle_q    <= settle_d;
         cin_q       <= cin_d;
         sample_q    <= sample_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         for (int k = 0; k < NUM_OUT; k++) begin
            err_q[k] <= err_d[k];
         end
      end
   end

`ifdef EVAL_CYCLE_COUNT_EN
   logic [31:0] cyc_q, cyc_d;

   // Busy-cycle counter: cleared on acceptance, counts APPLY/SETTLE/COMPARE cycles only.
   always_comb begin
      cyc_d = cyc_q;
      if (accept_s) begin
         cyc_d = 32'd0;
      end else if ((state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_COMPARE)) begin
         cyc_d = cyc_q + 32'd1;
      end else begin
         cyc_d = cyc_q;
      end
   end

   // Busy-cycle counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= 32'd0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign eval_cycles = cyc_q;
`endif

   assign circuit_in            = cin_q;
   assign ready_to_process      = ready_q;
   assign done_processing_chrom = done_q;

   generate
      for (genvar g = 0; g < NUM_OUT; g++) begin : g_sum
         assign error_sum[g*32 +: 32] = err_q[g];
      end
   endgenerate

endmodule

// File: doc/chrom_fitness_evaluator.md
Name: chrom_fitness_evaluator

Overview:
- Fabric-side responder to the HPS chromosome-evaluation handshake.
- On start_processing_chrom, it drives up to NUM_SEQ input vectors into the evolved circuit and samples the circuit outputs after a settle delay.
- Each sampled output is compared against the expected output, gated by a per-vector valid mask, and mismatches are accumulated into per-output-bit error sums.
- Completion is reported by raising done_processing_chrom; the block then completes a four-phase handshake with the HPS via done_processing_feedback.

Parameters:
NUM_SEQ, 16, maximum number of vectors per evaluation (input/expected/valid word count)
NUM_OUT, 8, number of circuit output bits, and therefore number of error sums
NUM_IN, 32, circuit input width (low bits of each input_sequence word)
SETTLE_CYCLES, 4, cycles circuit_in is held stable before circuit_out is sampled (minimum 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_processing_chrom  in  1  HPS start request (level)
done_processing_feedback  in  1  HPS acknowledge of done (level)
sequences_to_process  in  32  number of vectors to evaluate
input_sequence  in  NUM_SEQ*32  packed words; word i occupies bits [32i+31:32i]
expected_output  in  NUM_SEQ*32  packed expected output words
valid_output  in  NUM_SEQ*32  packed mask words; bit k=1 means output bit k is checked
circuit_in  out  NUM_IN  stimulus to the evolved circuit
circuit_out  in  NUM_OUT  response from the evolved circuit
ready_to_process  out  1  high only in IDLE
done_processing_chrom  out  1  high in DONE
error_sum  out  NUM_OUT*32  packed error sums; sum k occupies bits [32k+31:32k]

Behaviour:
- Reset values: all outputs 0, except ready_to_process=1. State is IDLE.
- Reset mid-operation returns the block to IDLE immediately and clears all registers.
- Sample register: seq_count = min(sequences_to_process, NUM_SEQ), latched on leaving IDLE.
- IDLE:
  - ready=1.
  - When start=1 and feedback=0: clear all error_sum, idx=0, latch seq_count.
  - If seq_count==0, go to DONE; otherwise go to APPLY.
- APPLY:
  - Register circuit_in = input_sequence[idx][NUM_IN-1:0].
  - Load settle counter = SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE:
  - Count down each cycle.
  - At count 0, register circuit_out into a sample register and go to COMPARE.
  - Total from APPLY to sample is SETTLE_CYCLES+1 cycles.
- COMPARE:
  - Compute mism = (sample ^ expected[idx][NUM_OUT-1:0]) & valid[idx][NUM_OUT-1:0].
  - For each k, error_sum_k += mism[k]. Addition is 32-bit unsigned and wraps, which is unreachable in practice.
  - If idx==seq_count-1, go to DONE; otherwise idx++ and go to APPLY.
- DONE:
  - done=1; error_sum is held stable.
  - When feedback=1, drop done and go to RELEASE.
- RELEASE:
  - done=0, ready=0.
  - Wait until start==0 and feedback==0, then go to IDLE.
  - This prevents a held start from re-triggering an evaluation.
- Input sampling rules:
  - start deasserting during APPLY/SETTLE/COMPARE is ignored; the evaluation completes.
  - feedback is ignored outside DONE.
  - input_sequence/expected/valid are sampled live and must be held stable by the HPS until done.
- Cycles per evaluation: seq_count*(SETTLE_CYCLES+2) + 1 from IDLE exit to done=1.
- error_sum is valid whenever done=1 and remains valid until the next start is accepted.

Optional Feature:
- Macro: EVAL_CYCLE_COUNT_EN.
- With the macro defined:
  - Adds output port eval_cycles (32 bits).
  - Counter is cleared on start acceptance and increments every cycle in APPLY/SETTLE/COMPARE.
  - The value is frozen in DONE/RELEASE/IDLE; reset value 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic pass case:
  - Stimulus: NUM_SEQ=16, SETTLE_CYCLES=4; circuit model circuit_out=circuit_in[7:0]; sequences_to_process=4; input=expected={0x11,0x22,0x33,0x44}; valid=0xFF; pulse start.
  - Response: done after 25 cycles; all error_sum=0; ready low during run.
- Single stuck bit:
  - Stimulus: same setup, but the model forces out bit 3 to 0; inputs 0x08,0x08,0x00.
  - Response: error_sum_3=2, all others 0.
- Valid mask:
  - Stimulus: expected=0xFF vs output 0x00; valid=0x0F; 16 sequences.
  - Response: error_sum_0..3=16, error_sum_4..7=0.
- Zero and clamped counts:
  - sequences_to_process=0 -> done 1 cycle after start, sums 0.
  - sequences_to_process=100 -> exactly 16 vectors evaluated (16 APPLY entries).
- Handshake:
  - Hold start=1 through DONE; assert feedback -> done drops next cycle, ready stays 0.
  - Drop start, then drop feedback -> ready=1; no second evaluation occurs.
- Reset mid-SETTLE at vector 2:
  - Response: outputs immediately return to reset values (ready=1, done=0, sums 0, circuit_in 0).
  - A subsequent full run produces correct sums.
